onchip_ram_avalon: RTL and testbench

Parametrised successor to the SOPC on-chip RAM slave. It infers a byte-enabled single-port RAM of configurable width and depth behind an Avalon-MM slave with pipelined reads, a selectable read latency (1 or 2), explicit readdatavalid/waitrequest, and an optional zero-fill engine that runs after reset. It sits on the system interconnect as program/data memory for the soft processor.

---
 rtl/onchip_ram_avalon.sv | 152 +++++++++++++++
 tb/tb_onchip_ram_avalon.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_ram_avalon.sv
// rtl/onchip_ram_avalon.sv - byte-enabled on-chip RAM behind a pipelined Avalon-MM slave with optional zero-fill
module onchip_ram_avalon #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 13,
    parameter int DEPTH          = 5120,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    chipselect,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic [DATA_WIDTH-1:0]   writedata,
    input  logic                    clken,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    output logic                    init_done
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    // Index width of the storage array; narrower than the bus address when DEPTH < 2**ADDR_WIDTH
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_L  = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clear_cnt;
    logic [ADDR_WIDTH-1:0]   clear_cnt_next;
    logic                    clear_we;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    in_range;
    logic                    accept;
    logic                    wr_acc;
    logic                    rd_acc;
    logic [IDX_W-1:0]        addr_idx;
    logic [IDX_W-1:0]        clr_idx;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    valid_reg;

    assign waitrequest   = (state == ST_CLEAR) | ~clken;
    assign init_done     = (state == ST_READY);
    assign in_range      = ({1'b0, address} < DEPTH_L);
    assign accept        = chipselect & (read | write) & ~waitrequest;
    // A simultaneous read+write is treated as a write only; the read gets no response
    assign wr_acc        = accept & write;
    assign rd_acc        = accept & read & ~write;
    assign addr_idx      = address[IDX_W-1:0];
    assign clr_idx       = clear_cnt[IDX_W-1:0];
    // Out-of-range reads still get a response, carrying zero
    assign rd_word       = in_range ? mem[addr_idx] : '0;
    // A response held while clken is low is only presented once clken returns
    assign readdatavalid = valid_reg & clken;

    // Zero-fill sequencing: walk every word once, then stay ready until reset
    always_comb begin
        state_next     = state;
        clear_cnt_next = clear_cnt;
        clear_we       = 1'b0;
        case (state)
            ST_CLEAR: begin
                clear_we = 1'b1;
                if ({1'b0, clear_cnt} == LAST_L) begin
                    state_next = ST_READY;
                end else begin
                    clear_cnt_next = clear_cnt + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // FSM and clear counter registers, frozen while clken is low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RESET_STATE;
            clear_cnt <= '0;
        end else if (clken) begin
            state     <= state_next;
            clear_cnt <= clear_cnt_next;
        end
    end

    // Storage write port: zero-fill during clear, otherwise byte-masked bus writes
    always_ff @(posedge clk) begin
        if (clken) begin
            if (clear_we) begin
                mem[clr_idx] <= '0;
            end else if (wr_acc && in_range) begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                    if (byteenable[i]) begin
                        mem[addr_idx][i*8 +: 8] <= writedata[i*8 +: 8];
                    end
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  s1_valid;
            logic [DATA_WIDTH-1:0] s1_data;

            // Two-stage read pipeline; readdata only moves when a response arrives
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    s1_valid  <= 1'b0;
                    s1_data   <= '0;
                    valid_reg <= 1'b0;
                    readdata  <= '0;
                end else if (clken) begin
                    s1_valid  <= rd_acc;
                    if (rd_acc) begin
                        s1_data <= rd_word;
                    end
                    valid_reg <= s1_valid;
                    if (s1_valid) begin
                        readdata <= s1_data;
                    end
                end
            end
        end else begin : g_lat1
            // Single-stage read pipeline; readdata only moves when a response arrives
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    valid_reg <= 1'b0;
                    readdata  <= '0;
                end else if (clken) begin
                    valid_reg <= rd_acc;
                    if (rd_acc) begin
                        readdata <= rd_word;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_onchip_ram_avalon.sv
// tb/tb_onchip_ram_avalon.sv - directed self-checking bench for onchip_ram_avalon
module tb_onchip_ram_avalon;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int DEP = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          chipselect;
    logic [AW-1:0] address;
    logic          read;
    logic          write;
    logic [3:0]    byteenable;
    logic [DW-1:0] writedata;
    logic          clken;

    logic [DW-1:0] rdata1, rdata2;
    logic          rdv1, rdv2;
    logic          wait1, wait2;
    logic          done1, done2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    onchip_ram_avalon #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
    ) u_dut_l1 (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
        .read(read), .write(write), .byteenable(byteenable), .writedata(writedata),
        .clken(clken), .readdata(rdata1), .readdatavalid(rdv1),
        .waitrequest(wait1), .init_done(done1)
    );

    onchip_ram_avalon #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
    ) u_dut_l2 (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
        .read(read), .write(write), .byteenable(byteenable), .writedata(writedata),
        .clken(clken), .readdata(rdata2), .readdatavalid(rdv2),
        .waitrequest(wait2), .init_done(done2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        byteenable = 4'h0;
        writedata  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle: drive the request, let one edge pass, return to idle
    task automatic bus(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [3:0] be, input logic [DW-1:0] wd);
        chipselect = 1'b1;
        read       = rd;
        write      = wr;
        address    = a;
        byteenable = be;
        writedata  = wd;
        tick();
        set_idle();
    endtask

    // Count clken-high cycles until init_done, flagging any early accept or response
    task automatic wait_fill(output int cycles, output int bad);
        cycles = 0;
        bad    = 0;
        while (!done1 && cycles < 100) begin
            if (!wait1 || !wait2 || rdv1 || rdv2) bad++;
            tick();
            cycles++;
        end
    endtask

    int cycles;
    int bad;

    initial begin
        reset_n = 1'b0;
        clken   = 1'b1;
        set_idle();
        repeat (3) tick();

        check_eq("reset_readdata",      rdata1, 32'h0);
        check_eq("reset_readdatavalid", {31'b0, rdv1 | rdv2}, 32'h0);
        check_eq("reset_init_done",     {31'b0, done1 | done2}, 32'h0);
        check_eq("reset_waitrequest",   {31'b0, wait1 & wait2}, 32'h1);

        // Zero-fill after reset release
        reset_n = 1'b1;
        wait_fill(cycles, bad);
        check_eq("fill_cycles",     cycles, 32'd16);
        check_eq("fill_wait_high",  bad, 32'd0);
        check_eq("fill_done_l2",    {31'b0, done2}, 32'h1);
        check_eq("ready_wait_low",  {31'b0, wait1}, 32'h0);
        for (int a = 0; a < DEP; a++) begin
            bus(1'b1, 1'b0, AW'(a), 4'h0, 32'h0);
            check_eq($sformatf("fill_rdv_%0d", a),  {31'b0, rdv1}, 32'h1);
            check_eq($sformatf("fill_data_%0d", a), rdata1, 32'h0);
        end
        tick();

        // Byte-lane writes
        bus(1'b0, 1'b1, 5'd3, 4'b1111, 32'hAABBCCDD);
        bus(1'b0, 1'b1, 5'd3, 4'b0101, 32'h11223344);
        bus(1'b0, 1'b1, 5'd3, 4'b0000, 32'hFFFFFFFF);
        bus(1'b1, 1'b0, 5'd3, 4'h0, 32'h0);
        check_eq("be_rdv",  {31'b0, rdv1}, 32'h1);
        check_eq("be_data", rdata1, 32'hAA22CC44);
        tick();

        // Latency-2 back-to-back reads
        bus(1'b0, 1'b1, 5'd0, 4'hF, 32'h10);
        bus(1'b0, 1'b1, 5'd1, 4'hF, 32'h20);
        bus(1'b0, 1'b1, 5'd2, 4'hF, 32'h30);
        bus(1'b1, 1'b0, 5'd0, 4'h0, 32'h0);
        check_eq("l2_first_not_yet", {31'b0, rdv2}, 32'h0);
        bus(1'b1, 1'b0, 5'd1, 4'h0, 32'h0);
        check_eq("l2_rdv0",  {31'b0, rdv2}, 32'h1);
        check_eq("l2_data0", rdata2, 32'h10);
        bus(1'b1, 1'b0, 5'd2, 4'h0, 32'h0);
        check_eq("l2_rdv1",  {31'b0, rdv2}, 32'h1);
        check_eq("l2_data1", rdata2, 32'h20);
        tick();
        check_eq("l2_rdv2",  {31'b0, rdv2}, 32'h1);
        check_eq("l2_data2", rdata2, 32'h30);
        tick();
        check_eq("l2_rdv_end",  {31'b0, rdv2}, 32'h0);
        check_eq("l2_data_hold", rdata2, 32'h30);

        // Write then immediate read; read+write collision
        bus(1'b0, 1'b1, 5'd7, 4'hF, 32'h5);
        bus(1'b1, 1'b0, 5'd7, 4'h0, 32'h0);
        check_eq("wr_rd_rdv",  {31'b0, rdv1}, 32'h1);
        check_eq("wr_rd_data", rdata1, 32'h5);
        bus(1'b1, 1'b1, 5'd7, 4'hF, 32'h9);
        check_eq("rw_no_rdv_l1", {31'b0, rdv1}, 32'h0);
        tick();
        check_eq("rw_no_rdv_l2", {31'b0, rdv2}, 32'h0);
        bus(1'b1, 1'b0, 5'd7, 4'h0, 32'h0);
        check_eq("rw_later_data", rdata1, 32'h9);

        // clken stall with a response pending
        tick();
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 5'd3;
        tick();
        set_idle();
        clken = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            check_eq($sformatf("stall_wait_%0d", c), {31'b0, wait1}, 32'h1);
            check_eq($sformatf("stall_rdv_%0d", c),  {31'b0, rdv1 | rdv2}, 32'h0);
            if (c < 2) tick();
        end
        @(posedge clk);
        #1;
        clken = 1'b1;
        #1;
        check_eq("stall_resume_rdv",  {31'b0, rdv1}, 32'h1);
        check_eq("stall_resume_data", rdata1, 32'hAA22CC44);
        tick();
        check_eq("stall_l1_done",    {31'b0, rdv1}, 32'h0);
        check_eq("stall_l2_rdv",     {31'b0, rdv2}, 32'h1);
        check_eq("stall_l2_data",    rdata2, 32'hAA22CC44);

        // Out-of-range read and write
        bus(1'b1, 1'b0, 5'd20, 4'h0, 32'h0);
        check_eq("oor_rdv",  {31'b0, rdv1}, 32'h1);
        check_eq("oor_data", rdata1, 32'h0);
        bus(1'b0, 1'b1, 5'd20, 4'hF, 32'hDEADBEEF);
        bus(1'b1, 1'b0, 5'd4, 4'h0, 32'h0);
        check_eq("oor_no_alias", rdata1, 32'h0);

        // Reset with a read in flight, then reset again mid-fill
        bus(1'b0, 1'b1, 5'd12, 4'hF, 32'h12345678);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 5'd3;
        tick();
        set_idle();
        reset_n = 1'b0;
        #1;
        check_eq("rst_flight_rdv",  {31'b0, rdv1 | rdv2}, 32'h0);
        check_eq("rst_readdata",    rdata1, 32'h0);
        check_eq("rst_done_low",    {31'b0, done1}, 32'h0);
        tick();
        check_eq("rst_flight_rdv2", {31'b0, rdv2}, 32'h0);
        reset_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 9; c++) begin
            if (!wait1 || rdv1 || rdv2) bad++;
            tick();
        end
        check_eq("midfill_clean", bad, 32'd0);
        check_eq("midfill_done",  {31'b0, done1}, 32'h0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        wait_fill(cycles, bad);
        check_eq("refill_cycles", cycles, 32'd16);
        check_eq("refill_clean",  bad, 32'd0);
        bus(1'b1, 1'b0, 5'd12, 4'h0, 32'h0);
        check_eq("refill_rdv",  {31'b0, rdv1}, 32'h1);
        check_eq("refill_data", rdata1, 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
